regfile_npin_snap: RTL and testbench

// - Parametrised img2col window register file: WR_PORTS independent write ports fill REG_NUM entries.
// - Per-entry fill bitmap; when every entry is written (AUTO_SNAP) or on rd_req, the whole file is

---
 rtl/regfile_npin_snap.sv | 164 ++++++++++++++++
 tb/tb_regfile_npin_snap.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_npin_snap.sv
`default_nettype none
// ============================================================================
// Module   : regfile_npin_snap
// Purpose  : img2col window register file with WR_PORTS independent write
//            ports, a per-entry fill bitmap and a whole-file snapshot that is
//            presented on a parallel valid/ready output. Filling the next
//            window overlaps draining the previous snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_npin_snap #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_NUM    = 9,
    parameter int WR_PORTS   = 2,
    parameter int ADDR_WIDTH = (REG_NUM > 1) ? $clog2(REG_NUM) : 1,
    parameter int AUTO_SNAP  = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WR_PORTS-1:0]            wr_en,
    input  logic [WR_PORTS*ADDR_WIDTH-1:0] wr_addr,
    input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data,
    input  logic                           clr,
    input  logic                           rd_req,
    output logic [DATA_WIDTH-1:0]          out_data [REG_NUM],
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [REG_NUM-1:0]             filled,
    output logic                           full,
    output logic                           err_addr,
    output logic                           err_drop
);

    localparam logic [0:0]          S_COLLECT = 1'b0;
    localparam logic [0:0]          S_PEND    = 1'b1;
    localparam logic [ADDR_WIDTH:0] c_REG_NUM = (ADDR_WIDTH + 1)'(REG_NUM);
    localparam logic                c_AUTO    = (AUTO_SNAP != 0);

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [DATA_WIDTH-1:0] r_entry    [REG_NUM];
    logic [DATA_WIDTH-1:0] w_entry_nx [REG_NUM];
    logic [DATA_WIDTH-1:0] r_out_data [REG_NUM];
    logic [REG_NUM-1:0]    r_filled;
    logic [REG_NUM-1:0]    w_hit;
    logic                  w_bad_addr;
    logic                  r_err_addr;
    logic                  r_err_drop;
    logic                  w_full;
    logic                  w_snap_trig;
    logic                  w_can_snap;
    logic                  w_snap;
    logic                  w_out_valid;

    // Decode all write ports; later (higher-index) ports overwrite earlier ones.
    always_comb begin
        w_hit      = '0;
        w_bad_addr = 1'b0;
        for (int e = 0; e < REG_NUM; e++) begin
            w_entry_nx[e] = r_entry[e];
        end
        for (int p = 0; p < WR_PORTS; p++) begin
            if (wr_en[p]) begin
                if ({1'b0, wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]} < c_REG_NUM) begin
                    for (int e = 0; e < REG_NUM; e++) begin
                        if (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e)) begin
                            w_entry_nx[e] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
                            w_hit[e]      = 1'b1;
                        end
                    end
                end else begin
                    w_bad_addr = 1'b1;
                end
            end
        end
    end

    assign w_full      = &r_filled;
    assign w_out_valid = (r_state == S_PEND);
    assign w_snap_trig = rd_req | (c_AUTO & w_full);
    assign w_can_snap  = ~w_out_valid | out_ready;
    assign w_snap      = w_snap_trig & w_can_snap;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: a snapshot always lands in PEND; a plain handshake returns to COLLECT.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_COLLECT: begin
                if (w_snap) begin
                    w_state_next = S_PEND;
                end
            end
            S_PEND: begin
                if (out_ready && !w_snap) begin
                    w_state_next = S_COLLECT;
                end
            end
            default: w_state_next = S_COLLECT;
        endcase
    end

    // Entry storage: writes are accepted in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < REG_NUM; e++) begin
                r_entry[e] <= '0;
            end
        end else begin
            r_entry <= w_entry_nx;
        end
    end

    // Snapshot capture uses the pre-edge entries, so this cycle's writes go to the next window.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < REG_NUM; e++) begin
                r_out_data[e] <= '0;
            end
        end else if (w_snap) begin
            r_out_data <= r_entry;
        end
    end

    // Fill bitmap: a write in the same cycle as a clear/snapshot survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filled <= '0;
        end else begin
            r_filled <= ((w_snap | clr) ? '0 : r_filled) | w_hit;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_addr <= 1'b0;
            r_err_drop <= 1'b0;
        end else begin
            if (w_bad_addr) begin
                r_err_addr <= 1'b1;
            end
            if (rd_req && !w_can_snap) begin
                r_err_drop <= 1'b1;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = w_out_valid;
    assign filled    = r_filled;
    assign full      = w_full;
    assign err_addr  = r_err_addr;
    assign err_drop  = r_err_drop;

endmodule
`default_nettype wire

// File: tb/tb_regfile_npin_snap.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_npin_snap
// Purpose  : Directed self-checking bench for regfile_npin_snap, one instance
//            with automatic snapshots and one with manual snapshots only.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_npin_snap;

    localparam int DW = 16;
    localparam int RN = 9;
    localparam int WP = 2;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: AUTO_SNAP = 1
    logic           a_rst = 1'b1;
    logic [WP-1:0]  a_wr_en = '0;
    logic [WP*AW-1:0] a_wr_addr = '0;
    logic [WP*DW-1:0] a_wr_data = '0;
    logic           a_clr = 1'b0;
    logic           a_rd_req = 1'b0;
    logic [DW-1:0]  a_out_data [RN];
    logic           a_out_valid;
    logic           a_out_ready = 1'b0;
    logic [RN-1:0]  a_filled;
    logic           a_full, a_err_addr, a_err_drop;

    // Instance B: AUTO_SNAP = 0
    logic           b_rst = 1'b1;
    logic [WP-1:0]  b_wr_en = '0;
    logic [WP*AW-1:0] b_wr_addr = '0;
    logic [WP*DW-1:0] b_wr_data = '0;
    logic           b_clr = 1'b0;
    logic           b_rd_req = 1'b0;
    logic [DW-1:0]  b_out_data [RN];
    logic           b_out_valid;
    logic           b_out_ready = 1'b0;
    logic [RN-1:0]  b_filled;
    logic           b_full, b_err_addr, b_err_drop;

    regfile_npin_snap #(.DATA_WIDTH(DW), .REG_NUM(RN), .WR_PORTS(WP), .AUTO_SNAP(1)) u_dut_a (
        .clk(clk), .rst(a_rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .clr(a_clr), .rd_req(a_rd_req), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .filled(a_filled), .full(a_full),
        .err_addr(a_err_addr), .err_drop(a_err_drop)
    );

    regfile_npin_snap #(.DATA_WIDTH(DW), .REG_NUM(RN), .WR_PORTS(WP), .AUTO_SNAP(0)) u_dut_b (
        .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .clr(b_clr), .rd_req(b_rd_req), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .filled(b_filled), .full(b_full),
        .err_addr(b_err_addr), .err_drop(b_err_drop)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic a_wr(input logic [1:0] en, input logic [3:0] ad0, input logic [15:0] d0,
                        input logic [3:0] ad1, input logic [15:0] d1);
        a_wr_en   = en;
        a_wr_addr = {ad1, ad0};
        a_wr_data = {d1, d0};
    endtask

    initial begin
        // ---------------- reset ----------------
        tick();
        a_rst = 1'b0;
        chk("rst_valid", 32'(a_out_valid), 32'h0);
        chk("rst_filled", 32'(a_filled), 32'h0);
        chk("rst_full", 32'(a_full), 32'h0);
        chk("rst_err_addr", 32'(a_err_addr), 32'h0);
        chk("rst_err_drop", 32'(a_err_drop), 32'h0);
        chk("rst_out0", 32'(a_out_data[0]), 32'h0);

        // ---------------- fill window: entries i get 0x10+i ----------------
        for (int k = 0; k < 5; k++) begin
            a_wr((k < 4) ? 2'b11 : 2'b01, 4'(2*k), 16'(16 + 2*k), 4'(2*k + 1), 16'(17 + 2*k));
            tick();
        end
        a_wr(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
        chk("fill_full", 32'(a_full), 32'h1);
        chk("fill_valid_pre", 32'(a_out_valid), 32'h0);
        tick();
        chk("fill_valid", 32'(a_out_valid), 32'h1);
        chk("fill_filled", 32'(a_filled), 32'h0);
        for (int i = 0; i < RN; i++) begin
            chk($sformatf("fill_out%0d", i), 32'(a_out_data[i]), 32'(16 + i));
        end

        // ---------------- collision and bad address ----------------
        a_wr(2'b11, 4'd3, 16'hAAAA, 4'd3, 16'h5555);
        tick();
        a_wr(2'b01, 4'd12, 16'hDEAD, 4'd0, 16'h0);
        tick();
        a_wr(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
        chk("bad_err_addr", 32'(a_err_addr), 32'h1);
        chk("bad_filled", 32'(a_filled), 32'h008);
        chk("pend_hold_valid", 32'(a_out_valid), 32'h1);
        // manual snapshot while PEND with out_ready reveals entry contents
        a_out_ready = 1'b1;
        a_rd_req    = 1'b1;
        tick();
        a_rd_req    = 1'b0;
        a_out_ready = 1'b0;
        chk("coll_entry3", 32'(a_out_data[3]), 32'h5555);
        chk("coll_entry4", 32'(a_out_data[4]), 32'h14);
        chk("coll_valid", 32'(a_out_valid), 32'h1);
        chk("coll_filled", 32'(a_filled), 32'h0);
        chk("coll_err_drop", 32'(a_err_drop), 32'h0);

        // ---------------- backpressure: refill with 0x100+i ----------------
        for (int k = 0; k < 5; k++) begin
            a_wr((k < 4) ? 2'b11 : 2'b01, 4'(2*k), 16'(256 + 2*k), 4'(2*k + 1), 16'(257 + 2*k));
            tick();
        end
        a_wr(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
        tick();
        chk("bp_full_held", 32'(a_full), 32'h1);
        chk("bp_filled_held", 32'(a_filled), 32'h1FF);
        chk("bp_out_stable", 32'(a_out_data[3]), 32'h5555);
        chk("bp_err_drop", 32'(a_err_drop), 32'h0);
        a_out_ready = 1'b1;
        tick();
        chk("bp_valid", 32'(a_out_valid), 32'h1);
        chk("bp_filled", 32'(a_filled), 32'h0);
        for (int i = 0; i < RN; i++) begin
            chk($sformatf("bp_out%0d", i), 32'(a_out_data[i]), 32'(256 + i));
        end
        tick();
        a_out_ready = 1'b0;
        chk("drain_valid", 32'(a_out_valid), 32'h0);
        chk("drain_hold", 32'(a_out_data[8]), 32'h108);

        // ---------------- clr with same-cycle write ----------------
        a_wr(2'b01, 4'd0, 16'h0040, 4'd0, 16'h0);
        tick();
        chk("pre_clr_filled", 32'(a_filled), 32'h001);
        a_clr = 1'b1;
        a_wr(2'b01, 4'd4, 16'h0044, 4'd0, 16'h0);
        tick();
        a_clr = 1'b0;
        a_wr(2'b00, 4'd0, 16'h0, 4'd0, 16'h0);
        chk("clr_filled", 32'(a_filled), 32'h010);

        // ---------------- reset mid-PEND ----------------
        a_rd_req = 1'b1;
        tick();
        a_rd_req = 1'b0;
        chk("man_valid", 32'(a_out_valid), 32'h1);
        chk("man_out4", 32'(a_out_data[4]), 32'h44);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        chk("rst2_valid", 32'(a_out_valid), 32'h0);
        chk("rst2_out4", 32'(a_out_data[4]), 32'h0);
        chk("rst2_err_addr", 32'(a_err_addr), 32'h0);
        chk("rst2_filled", 32'(a_filled), 32'h0);

        // ---------------- manual-only instance ----------------
        b_rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            b_wr_en   = 2'b11;
            b_wr_addr = {4'(2*k + 1), 4'(2*k)};
            b_wr_data = {16'(16'hB1 + 2*k), 16'(16'hB0 + 2*k)};
            tick();
        end
        b_wr_en = 2'b00;
        chk("b_filled", 32'(b_filled), 32'h00F);
        chk("b_valid_pre", 32'(b_out_valid), 32'h0);
        b_rd_req = 1'b1;
        tick();
        b_rd_req = 1'b0;
        chk("b_valid", 32'(b_out_valid), 32'h1);
        chk("b_out0", 32'(b_out_data[0]), 32'hB0);
        chk("b_out3", 32'(b_out_data[3]), 32'hB3);
        chk("b_out4", 32'(b_out_data[4]), 32'h0);
        chk("b_out8", 32'(b_out_data[8]), 32'h0);
        chk("b_filled_clr", 32'(b_filled), 32'h0);
        // fill all entries: no auto snapshot in manual mode
        for (int k = 0; k < 5; k++) begin
            b_wr_en   = (k < 4) ? 2'b11 : 2'b01;
            b_wr_addr = {4'(2*k + 1), 4'(2*k)};
            b_wr_data = {16'(16'hC1 + 2*k), 16'(16'hC0 + 2*k)};
            tick();
        end
        b_wr_en = 2'b00;
        b_out_ready = 1'b0;
        b_rd_req = 1'b1;
        tick();
        b_rd_req = 1'b0;
        chk("b_drop_err", 32'(b_err_drop), 32'h1);
        chk("b_drop_valid", 32'(b_out_valid), 32'h1);
        chk("b_drop_out0", 32'(b_out_data[0]), 32'hB0);
        chk("b_full_noauto", 32'(b_full), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
